// File: rtl/ysyx_rou_commit_ctrl_pkg.sv
// ysyx_pkg: shared commit kinds, commit FSM states and flush counter sizing
`ifndef YSYX_XLEN
`define YSYX_XLEN 64
`endif
package ysyx_pkg;
  typedef enum logic [2:0] {
    K_NORMAL  = 3'd0,
    K_STORE   = 3'd1,
    K_CSR     = 3'd2,
    K_TRAP    = 3'd3,
    K_FENCE_I = 3'd4
  } commit_kind_e;
  typedef enum logic [1:0] {
    S_IDLE,
    S_FENCE_DRAIN,
    S_FENCE_WAIT,
    S_FLUSH
  } commit_state_e;
  function automatic int flush_cnt_w(input int cycles);
    return $clog2(cycles + 1);
  endfunction
endpackage

// File: rtl/ysyx_rou_commit_ctrl.sv
// ysyx_rou_commit_ctrl: ROB head commit sequencer with serialising flush and retire counter
`ifndef YSYX_XLEN
`define YSYX_XLEN 64
`endif
module ysyx_rou_commit_ctrl
  import ysyx_pkg::*;
#(
  parameter int XLEN         = `YSYX_XLEN,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             head_valid,
  input  logic [2:0]       head_kind,
  input  logic [XLEN-1:0]  head_pc,
  input  logic             head_flush,
  output logic             head_pop,
  output logic             cmu_valid,
  output logic             sq_valid,
  input  logic             sq_ready,
  input  logic             sq_empty,
  output logic             csr_valid,
  output logic             csr_trap,
  output logic [XLEN-1:0]  csr_pc,
  output logic             fence_i_req,
  input  logic             fence_i_done,
  output logic             flush_pipe,
  output logic             busy,
  output logic [CNT_W-1:0] retire_cnt
);
  localparam int FW = flush_cnt_w(FLUSH_CYCLES);
  commit_state_e state;
  logic [FW-1:0] flush_cnt;
  logic idle, is_trap, to_flush;
  always_comb begin
    idle      = !reset && state == S_IDLE && head_valid;
    is_trap   = head_kind == K_TRAP || head_kind > K_FENCE_I;
    sq_valid  = idle && head_kind == K_STORE;
    csr_valid = idle && (head_kind == K_CSR || is_trap);
    csr_trap  = csr_valid && is_trap;
    csr_pc    = csr_valid ? head_pc : '0;
    head_pop  = csr_valid || (idle && head_kind == K_NORMAL) || (sq_valid && sq_ready) ||
                (!reset && state == S_FENCE_WAIT && head_valid && fence_i_done);
    cmu_valid = head_pop && !csr_trap;
    to_flush  = head_pop && (csr_valid || head_flush || state == S_FENCE_WAIT);
    busy      = state != S_IDLE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      flush_cnt   <= '0;
      retire_cnt  <= '0;
      fence_i_req <= 1'b0;
      flush_pipe  <= 1'b0;
    end else begin
      retire_cnt  <= retire_cnt + CNT_W'(cmu_valid);
      fence_i_req <= 1'b0;
      flush_pipe  <= 1'b0;
      if (to_flush) begin
        state      <= S_FLUSH;
        flush_cnt  <= FW'(1);
        flush_pipe <= 1'b1;
      end else begin
        case (state)
          S_IDLE:
            if (head_valid && head_kind == K_FENCE_I) begin
              state       <= sq_empty ? S_FENCE_WAIT : S_FENCE_DRAIN;
              fence_i_req <= sq_empty;
            end
          S_FENCE_DRAIN:
            if (sq_empty) begin
              state       <= S_FENCE_WAIT;
              fence_i_req <= 1'b1;
            end
          S_FLUSH:
            if (flush_cnt == FW'(FLUSH_CYCLES)) begin
              state     <= S_IDLE;
              flush_cnt <= '0;
            end else begin
              flush_cnt  <= flush_cnt + FW'(1);
              flush_pipe <= 1'b1;
            end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ysyx_rou_commit_ctrl.sv
// tb_ysyx_rou_commit_ctrl: table vectors, directed sequences and random run against a reference model
module tb_ysyx_rou_commit_ctrl;
  localparam int FC = 2;
  localparam int CW = 8;
  localparam int XL = 64;
  logic clock = 1'b0;
  logic reset, head_valid, head_flush, sq_ready, sq_empty, fence_i_done;
  logic [2:0] head_kind;
  logic [XL-1:0] head_pc, csr_pc;
  logic head_pop, cmu_valid, sq_valid, csr_valid, csr_trap, fence_i_req, flush_pipe, busy;
  logic [CW-1:0] retire_cnt;
  always #5 clock = ~clock;
  ysyx_rou_commit_ctrl #(.XLEN(XL), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .head_valid(head_valid), .head_kind(head_kind),
    .head_pc(head_pc), .head_flush(head_flush), .head_pop(head_pop), .cmu_valid(cmu_valid),
    .sq_valid(sq_valid), .sq_ready(sq_ready), .sq_empty(sq_empty), .csr_valid(csr_valid),
    .csr_trap(csr_trap), .csr_pc(csr_pc), .fence_i_req(fence_i_req), .fence_i_done(fence_i_done),
    .flush_pipe(flush_pipe), .busy(busy), .retire_cnt(retire_cnt)
  );
  int n_chk = 0, n_fail = 0;
  // model: remaining flush cycles, fence progress (0 none, 1 draining, 2 awaiting done)
  int flush_left = 0, fence = 0;
  bit req_q = 0;
  logic [CW-1:0] m_cnt = '0;
  bit m_pop, a_pop, a_cmu, a_sq, a_csr, a_trap;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step(input bit r, input bit hv, input logic [2:0] k, input logic [63:0] pc,
                      input bit hf, input bit sr, input bit se, input bit fd);
    bit busy_e, trap, free, pop, cmu, sqv, csrv;
    reset = r; head_valid = hv; head_kind = k; head_pc = pc; head_flush = hf;
    sq_ready = sr; sq_empty = se; fence_i_done = fd;
    #1;
    trap   = (k == 3) || (k >= 5);
    busy_e = flush_left > 0 || fence != 0;
    free   = !r && !busy_e && hv;
    if (r || flush_left > 0 || fence == 1) pop = 0;
    else if (fence == 2) pop = hv && fd;
    else pop = free && (k == 0 || (k == 1 && sr) || k == 2 || trap);
    sqv  = free && k == 1;
    csrv = free && (k == 2 || trap);
    cmu  = pop && !(csrv && trap);
    chk("head_pop", head_pop, pop);
    chk("cmu_valid", cmu_valid, cmu);
    chk("sq_valid", sq_valid, sqv);
    chk("csr_valid", csr_valid, csrv);
    chk("csr_trap", csr_trap, csrv && trap);
    chk("csr_pc", csr_pc, csrv ? pc : 64'd0);
    chk("fence_i_req", fence_i_req, req_q);
    chk("flush_pipe", flush_pipe, flush_left > 0);
    chk("busy", busy, busy_e);
    chk("retire_cnt", retire_cnt, m_cnt);
    a_pop = head_pop; a_cmu = cmu_valid; a_sq = sq_valid; a_csr = csr_valid; a_trap = csr_trap;
    m_pop = pop;
    if (!r && fence != 0) assert (hv) else $error("head_valid dropped during fence");
    if (r) begin
      flush_left = 0; fence = 0; req_q = 0; m_cnt = '0;
    end else begin
      m_cnt = m_cnt + CW'(cmu);
      req_q = 0;
      if (flush_left > 0) flush_left--;
      else if (fence == 1) begin
        if (se) begin fence = 2; req_q = 1; end
      end else if (fence == 2) begin
        if (pop) begin fence = 0; flush_left = FC; end
      end else if (hv && k == 4) begin
        if (se) begin fence = 2; req_q = 1; end else fence = 1;
      end else if (pop && (hf || csrv)) flush_left = FC;
    end
    @(negedge clock);
  endtask
  typedef struct {
    bit hv; logic [2:0] k; bit sr;
    bit pop, cmu, sq, csr, trap;
  } vec_t;
  vec_t tv[10];
  bit cv, cf;
  logic [2:0] ck;
  logic [63:0] cpc;
  initial begin
    reset = 1; head_valid = 0; head_kind = 0; head_pc = 0; head_flush = 0;
    sq_ready = 0; sq_empty = 1; fence_i_done = 0;
    repeat (2) @(negedge clock);
    tv[0] = '{0, 0, 0, 0, 0, 0, 0, 0};
    tv[1] = '{1, 0, 0, 1, 1, 0, 0, 0};
    tv[2] = '{1, 1, 0, 0, 0, 1, 0, 0};
    tv[3] = '{1, 1, 1, 1, 1, 1, 0, 0};
    tv[4] = '{1, 2, 0, 1, 1, 0, 1, 0};
    tv[5] = '{1, 3, 0, 1, 0, 0, 1, 1};
    tv[6] = '{1, 4, 1, 0, 0, 0, 0, 0};
    tv[7] = '{1, 5, 0, 1, 0, 0, 1, 1};
    tv[8] = '{1, 6, 1, 1, 0, 0, 1, 1};
    tv[9] = '{1, 7, 0, 1, 0, 0, 1, 1};
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, 0, 0, 0, 1, 0);
      step(0, tv[i].hv, tv[i].k, 64'h1000 + 64'(i), 0, tv[i].sr, 1, 0);
      chk("tv_pop", a_pop, tv[i].pop);
      chk("tv_cmu", a_cmu, tv[i].cmu);
      chk("tv_sq", a_sq, tv[i].sq);
      chk("tv_csr", a_csr, tv[i].csr);
      chk("tv_trap", a_trap, tv[i].trap);
    end
    // four back-to-back normal commits
    step(1, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 64'h100 + 64'(4 * i), 0, 0, 1, 0);
    chk("seq_normal_cnt", retire_cnt, 4);
    chk("seq_normal_noflush", flush_pipe, 0);
    // store held off by sq_ready for three cycles
    step(1, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 64'h200, 0, 0, 1, 0);
    step(0, 1, 1, 64'h200, 0, 1, 1, 0);
    chk("seq_store_pop", a_pop, 1);
    chk("seq_store_cnt", retire_cnt, 1);
    // CSR commit, then a head ignored through the flush window
    step(1, 0, 0, 0, 0, 0, 1, 0);
    step(0, 1, 2, 64'h80000010, 0, 0, 1, 0);
    chk("seq_csr_flush1", flush_pipe, 1);
    step(0, 1, 0, 64'h300, 0, 0, 1, 0);
    chk("seq_csr_flush2", flush_pipe, 1);
    step(0, 1, 0, 64'h300, 0, 0, 1, 0);
    chk("seq_csr_idle", busy, 0);
    chk("seq_csr_noflush", flush_pipe, 0);
    // trap is popped but not retired
    step(1, 0, 0, 0, 0, 0, 1, 0);
    step(0, 1, 3, 64'h400, 0, 0, 1, 0);
    chk("seq_trap_pop", a_pop, 1);
    chk("seq_trap_cmu", a_cmu, 0);
    chk("seq_trap_cnt", retire_cnt, 0);
    chk("seq_trap_flush", flush_pipe, 1);
    // fence.i draining a busy store queue
    step(1, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 4, 64'h500, 0, 0, 0, 0);
    chk("seq_fence_noreq", fence_i_req, 0);
    step(0, 1, 4, 64'h500, 0, 0, 1, 0);
    chk("seq_fence_req", fence_i_req, 1);
    step(0, 1, 4, 64'h500, 0, 0, 1, 0);
    chk("seq_fence_pulse", fence_i_req, 0);
    step(0, 1, 4, 64'h500, 0, 0, 1, 0);
    step(0, 1, 4, 64'h500, 0, 0, 1, 0);
    step(0, 1, 4, 64'h500, 0, 0, 1, 1);
    chk("seq_fence_pop", a_pop, 1);
    chk("seq_fence_cmu", a_cmu, 1);
    chk("seq_fence_flush", flush_pipe, 1);
    chk("seq_fence_cnt", retire_cnt, 1);
    // reset while waiting for fence_i_done
    step(1, 0, 0, 0, 0, 0, 1, 0);
    step(0, 1, 4, 64'h600, 0, 0, 1, 0);
    chk("seq_rst_busy_pre", busy, 1);
    step(1, 1, 4, 64'h600, 0, 0, 1, 0);
    chk("seq_rst_busy", busy, 0);
    chk("seq_rst_req", fence_i_req, 0);
    chk("seq_rst_cnt", retire_cnt, 0);
    step(0, 0, 4, 64'h600, 0, 0, 1, 1);
    chk("seq_rst_late_done", a_pop, 0);
    chk("seq_rst_idle", busy, 0);
    // randomized run with occasional resets
    cv = 0; ck = 0; cpc = 0; cf = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!cv && $urandom_range(3) != 0) begin
        cv = 1;
        ck = 3'($urandom_range(7));
        if ($urandom_range(1) == 1) ck = 3'($urandom_range(1));
        cpc = {$urandom, $urandom};
        cf = ($urandom_range(7) == 0);
      end
      step($urandom_range(199) == 0, cv, ck, cpc, cf, $urandom_range(1) == 1,
           $urandom_range(1) == 1, $urandom_range(2) == 0);
      if (m_pop) cv = 0;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
